// File: rtl/alu_pkg.sv
// ALU-side shared definitions: bit positions of the {EQ,LT} compare result.
package alu_pkg;

    localparam int unsigned EQ     = 0;
    localparam int unsigned LT     = 1;
    localparam int unsigned FLAG_W = 2;

endpackage

// File: rtl/cond_pkg.sv
// Condition unit types: condition codes and in-flight flag stage record.
package cond_pkg;

    typedef enum logic [2:0] {
        C_EQ,
        C_NE,
        C_LT,
        C_GE,
        C_LE,
        C_GT,
        C_AL,
        C_NV
    } cond_e;

    typedef struct packed {
        logic v;
        logic eq;
        logic lt;
    } flag_stage_t;

endpackage

// File: rtl/cond_unit_eval.sv
// Pure condition evaluator over {eq,lt}; shared with decode for static prediction.
module cond_eval
    import cond_pkg::*;
(
    input  cond_e cond,
    input  logic  eq,
    input  logic  lt,
    output logic  hit
);

    always_comb begin
        hit = 1'b0;
        unique case (cond)
            C_EQ: hit = eq;
            C_NE: hit = ~eq;
            C_LT: hit = lt;
            C_GE: hit = ~lt;
            C_LE: hit = lt | eq;
            C_GT: hit = ~lt & ~eq;
            C_AL: hit = 1'b1;
            C_NV: hit = 1'b0;
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Condition unit: flag pipeline, forwarding, condition evaluation
// and registered branch redirect.
module cond_unit
    import cond_pkg::*;
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int PIPE_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_setflags,
    input  logic [1:0]      ex_cmp_res,
    input  cond_e           ex_cond,
    input  logic            ex_branch,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_stall,
    input  logic            flush,
    output logic            cond_true,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [1:0]      flags,
    output logic            pending
);

    flag_stage_t [PIPE_DEPTH-1:0] s;
    flag_stage_t                  s_in;
    logic                         accept;
    logic                         take;
    logic                         fwd_eq;
    logic                         fwd_lt;

    assign accept = ex_valid & ~ex_stall & ~flush & ~redirect_valid;

    always_comb begin
        s_in    = '0;
        s_in.v  = accept & ex_setflags;
        s_in.eq = ex_cmp_res[EQ];
        s_in.lt = ex_cmp_res[LT];
    end

    for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_stage
        flag_stage_t st;
        flag_stage_t nxt;

        if (g == 0) begin : g_head
            assign nxt = s_in;
        end else begin : g_body
            assign nxt = s[g-1];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                st <= '0;
            end else if (flush) begin
                st.v <= 1'b0;
            end else if (!ex_stall) begin
                st <= nxt;
            end
        end

        assign s[g] = st;
    end

    // Youngest valid stage (lowest index) overrides committed flags.
    always_comb begin
        fwd_eq  = flags[EQ];
        fwd_lt  = flags[LT];
        pending = 1'b0;
        for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
            pending = pending | s[i].v;
            if (s[i].v) begin
                fwd_eq = s[i].eq;
                fwd_lt = s[i].lt;
            end
        end
    end

    cond_eval u_eval (
        .cond (ex_cond),
        .eq   (fwd_eq),
        .lt   (fwd_lt),
        .hit  (cond_true)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= '0;
        end else if (!flush && !ex_stall && s[PIPE_DEPTH-1].v) begin
            flags[EQ] <= s[PIPE_DEPTH-1].eq;
            flags[LT] <= s[PIPE_DEPTH-1].lt;
        end
    end

    assign take = accept & ex_branch & cond_true;

    // Pulse is one cycle by construction: accept is blocked while it is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= take;
            if (take) begin
                redirect_pc <= ex_target;
            end
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: directed per-cycle vectors,
// expectations queued by stimulus and checked by a negedge monitor.
module tb_cond_unit;
    import cond_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_setflags;
    logic [1:0]  ex_cmp_res;
    cond_e       ex_cond;
    logic        ex_branch;
    logic [31:0] ex_target;
    logic        ex_stall;
    logic        flush;
    logic        cond_true;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  flags;
    logic        pending;

    typedef struct {
        int          id;
        logic        ct;
        logic [1:0]  fl;
        logic        pd;
        logic        rv;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   n_id   = 0;

    cond_unit #(.XLEN(32), .PIPE_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_setflags    (ex_setflags),
        .ex_cmp_res     (ex_cmp_res),
        .ex_cond        (ex_cond),
        .ex_branch      (ex_branch),
        .ex_target      (ex_target),
        .ex_stall       (ex_stall),
        .flush          (flush),
        .cond_true      (cond_true),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flags          (flags),
        .pending        (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input int id, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL T%0d %s: got %0h expected %0h", id, nm, act, exp);
        end
    endtask

    // Monitor: outputs are sampled mid-cycle, once per queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.id, "cond_true", 32'(cond_true), 32'(e.ct));
            chk(e.id, "flags", 32'(flags), 32'(e.fl));
            chk(e.id, "pending", 32'(pending), 32'(e.pd));
            chk(e.id, "redirect_valid", 32'(redirect_valid), 32'(e.rv));
            chk(e.id, "redirect_pc", redirect_pc, e.pc);
        end
    end

    // One cycle: drive just after the edge, queue what must be seen this cycle.
    task automatic cyc(input logic r, input logic v, input logic sf,
                       input logic [1:0] cmp, input cond_e cd,
                       input logic br, input logic [31:0] tgt,
                       input logic st, input logic fl_in,
                       input logic ect, input logic [1:0] efl,
                       input logic epd, input logic erv,
                       input logic [31:0] epc);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = r;
        ex_valid    = v;
        ex_setflags = sf;
        ex_cmp_res  = cmp;
        ex_cond     = cd;
        ex_branch   = br;
        ex_target   = tgt;
        ex_stall    = st;
        flush       = fl_in;
        n_id++;
        e.id = n_id;
        e.ct = ect;
        e.fl = efl;
        e.pd = epd;
        e.rv = erv;
        e.pc = epc;
        q.push_back(e);
    endtask

    initial begin
        rst         = 1'b1;
        ex_valid    = 1'b0;
        ex_setflags = 1'b0;
        ex_cmp_res  = 2'b00;
        ex_cond     = C_GE;
        ex_branch   = 1'b0;
        ex_target   = '0;
        ex_stall    = 1'b0;
        flush       = 1'b0;
        repeat (2) @(posedge clk);

        // cmp = {lt,eq}; flags = {lt,eq}
        //   r v sf cmp    cond br tgt         st fl  ct fl     pd rv pc
        cyc(0,0,0,2'b00,C_GE,0,32'h0,      0,0, 1,2'b00,0,0,32'h0);
        cyc(0,1,1,2'b10,C_GE,0,32'h0,      0,0, 1,2'b00,0,0,32'h0);
        cyc(0,0,0,2'b00,C_LT,0,32'h0,      0,0, 1,2'b00,1,0,32'h0);
        cyc(0,0,0,2'b00,C_LT,0,32'h0,      0,0, 1,2'b00,1,0,32'h0);
        cyc(0,0,0,2'b00,C_LT,0,32'h0,      0,0, 1,2'b10,0,0,32'h0);
        // back-to-back compares, youngest wins
        cyc(0,1,1,2'b01,C_EQ,0,32'h0,      0,0, 0,2'b10,0,0,32'h0);
        cyc(0,1,1,2'b10,C_EQ,0,32'h0,      0,0, 1,2'b10,1,0,32'h0);
        cyc(0,0,0,2'b00,C_EQ,0,32'h0,      0,0, 0,2'b10,1,0,32'h0);
        cyc(0,0,0,2'b00,C_LT,0,32'h0,      0,0, 1,2'b01,1,0,32'h0);
        cyc(0,0,0,2'b00,C_EQ,0,32'h0,      0,0, 0,2'b10,0,0,32'h0);
        // taken branch, then a taken branch inside the pulse
        cyc(0,1,0,2'b00,C_NE,1,32'h1000,   0,0, 1,2'b10,0,0,32'h0);
        cyc(0,1,0,2'b00,C_NE,1,32'h2000,   0,0, 1,2'b10,0,1,32'h1000);
        cyc(0,0,0,2'b00,C_NE,0,32'h0,      0,0, 1,2'b10,0,0,32'h1000);
        cyc(0,1,0,2'b00,C_EQ,1,32'h3000,   0,0, 0,2'b10,0,0,32'h1000);
        cyc(0,0,0,2'b00,C_AL,0,32'h0,      0,0, 1,2'b10,0,0,32'h1000);
        cyc(0,0,0,2'b00,C_NV,0,32'h0,      0,0, 0,2'b10,0,0,32'h1000);
        // two pending writes then flush with a taken branch
        cyc(0,1,1,2'b01,C_LE,0,32'h0,      0,0, 1,2'b10,0,0,32'h1000);
        cyc(0,1,1,2'b00,C_GT,0,32'h0,      0,0, 0,2'b10,1,0,32'h1000);
        cyc(0,1,0,2'b00,C_GE,1,32'h4000,   0,1, 1,2'b10,1,0,32'h1000);
        cyc(0,0,0,2'b00,C_GE,0,32'h0,      0,0, 0,2'b10,0,0,32'h1000);
        // pending write held across a 3-cycle stall, reset mid-stall
        cyc(0,1,1,2'b01,C_EQ,0,32'h0,      0,0, 0,2'b10,0,0,32'h1000);
        cyc(0,0,0,2'b00,C_EQ,0,32'h0,      1,0, 1,2'b10,1,0,32'h1000);
        cyc(0,0,0,2'b00,C_EQ,0,32'h0,      1,0, 1,2'b10,1,0,32'h1000);
        cyc(0,1,1,2'b10,C_EQ,0,32'h0,      1,0, 1,2'b10,1,0,32'h1000);
        cyc(1,0,0,2'b00,C_EQ,0,32'h0,      1,0, 1,2'b10,1,0,32'h1000);
        cyc(0,0,0,2'b00,C_EQ,0,32'h0,      0,0, 0,2'b00,0,0,32'h0);
        // redirect drops even when stall rises under it
        cyc(0,1,0,2'b00,C_AL,1,32'h5000,   0,0, 1,2'b00,0,0,32'h0);
        cyc(0,0,0,2'b00,C_AL,0,32'h0,      1,0, 1,2'b00,0,1,32'h5000);
        cyc(0,0,0,2'b00,C_AL,0,32'h0,      1,0, 1,2'b00,0,0,32'h5000);

        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (q.size() > 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: got %0d queued expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
